// File: rtl/asym_sdp_ram_pipelined.sv
// asym_sdp_ram_pipelined: asymmetric simple-dual-port RAM with optional output register and post-reset zero fill
module asym_sdp_ram_pipelined #(
    parameter int WR_WIDTH = 9,
    parameter int RD_WIDTH = 18,
    parameter int DEPTH_BITS = 18432,
    parameter int OUT_REG = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int WR_ADDR_WIDTH = $clog2(DEPTH_BITS / WR_WIDTH),
    localparam int RD_ADDR_WIDTH = $clog2(DEPTH_BITS / RD_WIDTH)
) (
    input  logic                     clock0,
    input  logic                     RESET_ni,
    input  logic                     WEN_i,
    input  logic [WR_ADDR_WIDTH-1:0] WR_ADDR_i,
    input  logic [WR_WIDTH-1:0]      WDATA_i,
    input  logic                     REN_i,
    input  logic [RD_ADDR_WIDTH-1:0] RD_ADDR_i,
    output logic [RD_WIDTH-1:0]      RDATA_o,
    output logic                     RVALID_o,
    output logic                     BUSY_o
);
    localparam int NW = WR_WIDTH < RD_WIDTH ? WR_WIDTH : RD_WIDTH;
    localparam int WR_R = WR_WIDTH / NW;
    localparam int RD_R = RD_WIDTH / NW;
    localparam int RATIO = WR_R * RD_R;
    localparam int WR_SH = $clog2(WR_R);
    localparam int RD_SH = $clog2(RD_R);
    localparam int N_WORDS = DEPTH_BITS / NW;
    localparam int NA = $clog2(N_WORDS);
    localparam int WR_DEPTH = DEPTH_BITS / WR_WIDTH;
    localparam int RD_DEPTH = DEPTH_BITS / RD_WIDTH;
    localparam logic [WR_ADDR_WIDTH:0] WR_LIM = (WR_ADDR_WIDTH + 1)'(WR_DEPTH);
    localparam logic [RD_ADDR_WIDTH:0] RD_LIM = (RD_ADDR_WIDTH + 1)'(RD_DEPTH);

    generate
        if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8) || WR_R * NW != WR_WIDTH ||
            RD_R * NW != RD_WIDTH || DEPTH_BITS % (NW * RATIO) != 0) begin : g_bad_cfg
            $error("asym_sdp_ram_pipelined: unsupported width ratio or depth");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                   state_q, state_d;
    logic [WR_ADDR_WIDTH-1:0] clr_q, clr_d;
    logic                     rv1_q, rv1_d, rv2_q, rv2_d;
    logic [RD_WIDTH-1:0]      rd1_q, rd1_d, rd2_q, rd2_d;
    logic [NW-1:0]            mem [N_WORDS];
    logic                     busy, mem_we, ren_ok;
    logic [WR_ADDR_WIDTH-1:0] mem_wa;
    logic [WR_WIDTH-1:0]      mem_wd;
    logic [NA-1:0]            wbase, rbase;
    logic [RD_WIDTH-1:0]      rd_word;

    // Storage is kept in narrow words; the wide port touches RATIO adjacent entries, low address in low bits.
    always_comb begin
        busy = state_q == S_CLEAR;
        state_d = busy && clr_q == WR_ADDR_WIDTH'(WR_DEPTH - 1) ? S_IDLE : state_q;
        clr_d = busy ? clr_q + 1'b1 : '0;
        mem_we = RESET_ni && (busy || (WEN_i && {1'b0, WR_ADDR_i} < WR_LIM));
        mem_wa = busy ? clr_q : WR_ADDR_i;
        mem_wd = busy ? '0 : WDATA_i;
        wbase = NA'(mem_wa) << WR_SH;
        rbase = NA'(RD_ADDR_i) << RD_SH;
        ren_ok = REN_i && !busy;
        rd_word = '0;
        for (int i = 0; i < RD_R; i++) rd_word[i*NW +: NW] = mem[rbase + NA'(i)];
        if ({1'b0, RD_ADDR_i} >= RD_LIM) rd_word = '0;
        rv1_d = ren_ok;
        rd1_d = ren_ok ? rd_word : rd1_q;
        rv2_d = rv1_q;
        rd2_d = rv1_q ? rd1_q : rd2_q;
    end

    always_ff @(posedge clock0)
        if (mem_we)
            for (int i = 0; i < WR_R; i++) mem[wbase + NA'(i)] <= mem_wd[i*NW +: NW];

    always_ff @(posedge clock0 or negedge RESET_ni)
        if (!RESET_ni) begin
            state_q <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_IDLE;
            clr_q <= '0;
            rv1_q <= 1'b0;
            rv2_q <= 1'b0;
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q <= clr_d;
            rv1_q <= rv1_d;
            rv2_q <= rv2_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end

    assign RDATA_o = OUT_REG != 0 ? rd2_q : rd1_q;
    assign RVALID_o = OUT_REG != 0 ? rv2_q : rv1_q;
    assign BUSY_o = busy;
endmodule
